// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared widths and state encoding for the countdown timer
package timer_pkg;

  localparam int SEC_W = 7;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

endpackage

// File: rtl/timer_tick_sync.sv
// rtl/timer_tick_sync.sv - brings the divider's CLK1 toggle into CLK100M and emits a tick per transition
module timer_tick_sync (
  input  logic CLK100M,
  input  logic RST_N,
  input  logic CLK1,
  output logic tick
);

  logic sync1, sync2, sync3;

  always_ff @(posedge CLK100M) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= CLK1;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Either edge counts; the tick is consumed on the third clock edge after CLK1 moves.
  assign tick = sync2 ^ sync3;

endmodule

// File: rtl/timer_countdown_core.sv
// rtl/timer_countdown_core.sv - loadable, pausable seconds countdown; optional warn output under TIMER_WARN_EN
module timer_countdown_core
  import timer_pkg::*;
#(
  parameter int MAX_SECONDS     = 99,
  parameter int DEFAULT_SECONDS = 60,
  parameter int WARN_SECONDS    = 10
) (
  input  logic             CLK100M,
  input  logic             RST_N,
  input  logic             CLK1,
  input  logic             load,
  input  logic [SEC_W-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [SEC_W-1:0] seconds_left,
  output logic [BCD_W-1:0] bcd_tens,
  output logic [BCD_W-1:0] bcd_ones,
  output logic             running,
  output logic             expired,
`ifdef TIMER_WARN_EN
  output logic             warn,
`endif
  output logic             done
);

  localparam logic [SEC_W-1:0] MAX_S = SEC_W'(MAX_SECONDS);
  localparam logic [SEC_W-1:0] DEF_S = SEC_W'(DEFAULT_SECONDS);

  if (MAX_SECONDS > 99 || DEFAULT_SECONDS > MAX_SECONDS || WARN_SECONDS > MAX_SECONDS) begin : g_param_check
    $error("timer_countdown_core: seconds parameters out of range");
  end

  timer_state_t state;
  logic         tick;

  timer_tick_sync u_tick_sync (
    .CLK100M (CLK100M),
    .RST_N   (RST_N),
    .CLK1    (CLK1),
    .tick    (tick)
  );

  always_ff @(posedge CLK100M) begin
    if (!RST_N) begin
      state        <= IDLE;
      seconds_left <= DEF_S;
      running      <= 1'b0;
      expired      <= 1'b0;
      done         <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        state        <= IDLE;
        seconds_left <= (load_value > MAX_S) ? MAX_S : load_value;
        running      <= 1'b0;
        done         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && seconds_left != '0) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          RUNNING: begin
            // Pause takes precedence over a coincident tick.
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick) begin
              if (seconds_left == SEC_W'(1)) begin
                seconds_left <= '0;
                state        <= EXPIRED;
                running      <= 1'b0;
                done         <= 1'b1;
                expired      <= 1'b1;
              end else begin
                seconds_left <= seconds_left - SEC_W'(1);
              end
            end
          end
          PAUSED: begin
            if (!pause) begin
              state   <= RUNNING;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK100M) begin
    if (!RST_N) begin
      bcd_tens <= BCD_W'(DEFAULT_SECONDS / 10);
      bcd_ones <= BCD_W'(DEFAULT_SECONDS % 10);
    end else begin
      bcd_tens <= BCD_W'(seconds_left / SEC_W'(10));
      bcd_ones <= BCD_W'(seconds_left % SEC_W'(10));
    end
  end

`ifdef TIMER_WARN_EN
  localparam logic [SEC_W-1:0] WARN_S = SEC_W'(WARN_SECONDS);

  always_ff @(posedge CLK100M) begin
    if (!RST_N) begin
      warn <= 1'b0;
    end else begin
      warn <= (state == RUNNING || state == PAUSED) &&
              (seconds_left != '0) && (seconds_left <= WARN_S);
    end
  end
`endif

endmodule

// File: doc/timer_countdown_core.md
Name: timer_countdown_core

Overview:
- Consumer end of the timer clock divider's slow-clock output. Samples the divider's CLK1 toggle signal as data in the CLK100M domain and turns each CLK1 transition into a one-cycle tick.
- Runs a loadable, pausable seconds countdown from those ticks. Drives the seconds value in binary and BCD to the seven-segment display path and flags expiry to game control.

Parameters:
- MAX_SECONDS, 99, upper clamp for loaded value; must be ≤ 99.
- DEFAULT_SECONDS, 60, count value after reset.
- WARN_SECONDS, 10, warning threshold; used only with the optional feature.

Ports:
- CLK100M  input  1  system clock, 100 MHz.
- RST_N  input  1  synchronous active-low reset, sampled on the CLK100M rising edge.
- CLK1  input  1  slow toggle from the divider; asynchronous to logic, treated as data.
- load  input  1  load load_value this cycle.
- load_value  input  7  seconds to load; clamped to MAX_SECONDS.
- start  input  1  single-cycle pulse; begins the countdown from IDLE.
- pause  input  1  level; holds the countdown while high.
- seconds_left  output  7  current count, binary.
- bcd_tens  output  4  tens digit of seconds_left.
- bcd_ones  output  4  ones digit of seconds_left.
- running  output  1  high in RUNNING.
- expired  output  1  one-cycle pulse on reaching 0.
- done  output  1  level high in EXPIRED.

Behaviour:
- Reset (RST_N low at a clock edge):
  - State goes to IDLE; seconds_left = DEFAULT_SECONDS.
  - bcd_tens and bcd_ones hold the BCD of DEFAULT_SECONDS.
  - running, expired and done are 0; synchronizer flops are 0.
  - Reset mid-countdown aborts the count immediately, with no expired pulse.
- Tick generation:
  - CLK1 passes through a 2-flop synchronizer, then an XOR edge detect against a third flop.
  - Both rising and falling CLK1 edges each produce a one-cycle tick. The divider toggles once per DIVISOR cycles, so this gives one tick per second.
  - Tick is asserted on the 3rd CLK100M edge after a CLK1 change.
  - The first CLK1 edge after reset does produce a tick.
- FSM states: IDLE, RUNNING, PAUSED, EXPIRED.
  - IDLE: start with seconds_left > 0 goes to RUNNING the next cycle. start with seconds_left == 0 is ignored.
  - RUNNING:
    - pause high goes to PAUSED.
    - A tick with seconds_left > 1 decrements the count.
    - A tick with seconds_left == 1 sets the count to 0, goes to EXPIRED, and pulses expired for exactly 1 cycle.
  - PAUSED: ticks are ignored; pause low goes back to RUNNING. A tick in the same cycle pause falls is ignored.
  - EXPIRED: done = 1 and the count holds 0. Only load or reset leave this state. start is ignored.
- load (any state, highest priority below reset):
  - seconds_left = min(load_value, MAX_SECONDS); state goes to IDLE.
  - Same-cycle start, tick or pause are ignored.
  - load_value of 0 loads 0 and stays in IDLE.
- Simultaneous tick and pause rising while RUNNING: pause wins, no decrement.
- Simultaneous tick and start in IDLE: go to RUNNING, no decrement that cycle.
- running is a registered decode of state == RUNNING.
- BCD outputs are registered, updated 1 cycle after seconds_left changes. They come from a combinational ÷10/%10 on the 7-bit value (valid 0–99).
- No wrap-around: the count never goes below 0.

Optional Feature:
- Macro TIMER_WARN_EN.
- When defined:
  - Adds output warn (1 bit, reset 0), registered.
  - warn is high when 0 < seconds_left ≤ WARN_SECONDS and the state is RUNNING or PAUSED.
  - warn is low in IDLE and EXPIRED.
- When undefined: no warn port and no threshold logic; all other behaviour is identical.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding constants: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, EXPIRED=2'd3;
  - SEC_W = 7;
  - BCD digit width = 4.
- One sub-module, timer_tick_sync (ports CLK100M, RST_N, CLK1, tick), containing the synchronizer and edge detect.
- The binary-to-BCD conversion stays inline.

Test Plan:
- Reset, then observe 5 cycles: seconds_left = 60, bcd_tens = 6, bcd_ones = 0, running = 0, done = 0, expired = 0.
- Load 5, start, toggle CLK1 5 times, 50 cycles apart:
  - count goes 4, 3, 2, 1, 0, each decrement 3 cycles after its CLK1 edge;
  - expired pulses exactly 1 cycle on the 0 transition;
  - done stays high afterwards.
- Load 120: seconds_left = 99, BCD 9/9. Load 0 then start: state stays IDLE, running = 0.
- Load 10, start, assert pause for 3 CLK1 toggles: count stays 10. Release pause and give 1 toggle: count = 9.
- Pulse load = 30 in the same cycle as a tick while RUNNING at 7: count = 30, state IDLE, no decrement.
- RST_N low mid-countdown at 3 with CLK1 toggling: count = 60 and no expired pulse. With TIMER_WARN_EN defined, load 12, start and tick: warn rises when count = 10 and falls on expiry.
